mips_mc_ctrl: RTL

- Multicycle sequencing controller for the single-issue MIPS datapath (PC, register file, ALU, shifter, branch unit, data RAM).
- Replaces the single-cycle decoder with an FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives per-state enables and mux selects, handshakes with instruction and data memories, traps on unsupported opcodes, and counts retired instructions.

---
 rtl/mips_mc_pkg.sv | 76 +++++++
 rtl/mips_mc_decode.sv | 36 +++
 rtl/mips_mc_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS sequencing controller.
// Contents: FSM state encodings, instruction class enum, opcode/funct
// constants, datapath select encodings and an immediate-extension helper.
package mips_mc_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsRalu    = 4'd0,
        ClsShift   = 4'd1,
        ClsIalu    = 4'd2,
        ClsLui     = 4'd3,
        ClsLw      = 4'd4,
        ClsSw      = 4'd5,
        ClsBr      = 4'd6,
        ClsJ       = 4'd7,
        ClsJal     = 4'd8,
        ClsIllegal = 4'd9
    } cls_e;

    // Primary opcodes
    localparam logic [5:0] OpRtype  = 6'h00;
    localparam logic [5:0] OpRegimm = 6'h01;
    localparam logic [5:0] OpJ      = 6'h02;
    localparam logic [5:0] OpJal    = 6'h03;
    localparam logic [5:0] OpBeq    = 6'h04;
    localparam logic [5:0] OpBne    = 6'h05;
    localparam logic [5:0] OpBlez   = 6'h06;
    localparam logic [5:0] OpBgtz   = 6'h07;
    localparam logic [5:0] OpAddi   = 6'h08;
    localparam logic [5:0] OpAddiu  = 6'h09;
    localparam logic [5:0] OpSlti   = 6'h0A;
    localparam logic [5:0] OpAndi   = 6'h0C;
    localparam logic [5:0] OpOri    = 6'h0D;
    localparam logic [5:0] OpXori   = 6'h0E;
    localparam logic [5:0] OpLui    = 6'h0F;
    localparam logic [5:0] OpLw     = 6'h23;
    localparam logic [5:0] OpSw     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FnSll    = 6'h00;
    localparam logic [5:0] FnSrl    = 6'h02;
    localparam logic [5:0] FnSra    = 6'h03;
    localparam logic [5:0] FnAluLo  = 6'h20;
    localparam logic [5:0] FnAluHi  = 6'h27;
    localparam logic [5:0] FnSlt    = 6'h2A;
    localparam logic [5:0] FnSltu   = 6'h2B;

    // Datapath select encodings
    localparam logic [1:0] PcSrcSeq    = 2'd0;
    localparam logic [1:0] PcSrcBranch = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    localparam logic [1:0] RegDstRt = 2'd0;
    localparam logic [1:0] RegDstRd = 2'd1;
    localparam logic [1:0] RegDstRa = 2'd2;

    localparam logic [2:0] WbAlu   = 3'd0;
    localparam logic [2:0] WbMem   = 3'd1;
    localparam logic [2:0] WbShift = 3'd2;
    localparam logic [2:0] WbLui   = 3'd3;
    localparam logic [2:0] WbLink  = 3'd4;

    // Logical immediates and lui take a zero-extended immediate.
    function automatic logic imm_zext(input logic [5:0] op);
        return (op == OpAndi) || (op == OpOri) || (op == OpXori) || (op == OpLui);
    endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier.
// Ports: opcode/funct/rt - instruction fields; cls - instruction class
// (ClsIllegal for any unsupported opcode, funct or REGIMM rt).
module mips_mc_decode
    import mips_mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output cls_e       cls
);

    always_comb begin
        cls = ClsIllegal;
        case (opcode)
            OpRtype: begin
                if (funct inside {[FnAluLo:FnAluHi], FnSlt, FnSltu}) begin
                    cls = ClsRalu;
                end else if (funct inside {FnSll, FnSrl, FnSra}) begin
                    cls = ClsShift;
                end
            end
            // bltz/bgez only; other REGIMM forms are not supported
            OpRegimm: if (rt inside {5'd0, 5'd1}) cls = ClsBr;
            OpJ:      cls = ClsJ;
            OpJal:    cls = ClsJal;
            OpBeq, OpBne, OpBlez, OpBgtz: cls = ClsBr;
            OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpXori: cls = ClsIalu;
            OpLui:    cls = ClsLui;
            OpLw:     cls = ClsLw;
            OpSw:     cls = ClsSw;
            default:  cls = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Inputs: instruction fields (opcode, funct, rt), branch_taken from the branch
// unit, imem_ready/dmem_ready memory handshakes.
// Outputs: per-state enables and selects for PC, IR, ALU, data RAM and the
// register file; debug state, retire pulse, wrapping retired_cnt, trap flag.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int unsigned CNT_W           = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_b,
    output logic             imm_unsigned,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [2:0]       wb_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             trap
);

    state_e           state_q, state_d;
    cls_e             cls_q, dec_cls;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q;

    mips_mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .rt     (rt),
        .cls    (dec_cls)
    );

    // run_q holds FETCH idle (no imem_req) until the first edge after reset
    // release, so every output reads 0 while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cls_q   <= ClsRalu;
            run_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (state_q == StDecode) cls_q <= dec_cls;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PcSrcSeq;
        alu_src_b    = 1'b0;
        imm_unsigned = 1'b0;
        dmem_re      = 1'b0;
        dmem_we      = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = RegDstRt;
        wb_sel       = WbAlu;
        retire       = 1'b0;
        trap         = 1'b0;
        case (state_q)
            StFetch: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = StDecode;
                    end
                end
            end
            StDecode: begin
                case (dec_cls)
                    ClsJ: begin
                        pc_we   = 1'b1;
                        pc_src  = PcSrcJump;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsIllegal: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = StTrap;
                        end else begin
                            // PC already advanced in FETCH: behaves as a NOP
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                alu_src_b    = cls_q inside {ClsIalu, ClsLw, ClsSw};
                imm_unsigned = (cls_q inside {ClsIalu, ClsLui}) && imm_zext(opcode);
                case (cls_q)
                    ClsBr: begin
                        pc_we   = branch_taken;
                        pc_src  = PcSrcBranch;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    ClsJal: begin
                        pc_we   = 1'b1;
                        pc_src  = PcSrcJump;
                        state_d = StWb;
                    end
                    ClsLw, ClsSw: state_d = StMem;
                    default:      state_d = StWb;
                endcase
            end
            StMem: begin
                dmem_re = (cls_q == ClsLw);
                dmem_we = (cls_q == ClsSw);
                if (dmem_ready) begin
                    if (cls_q == ClsLw) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StWb: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
                case (cls_q)
                    ClsRalu:  begin reg_dst = RegDstRd; wb_sel = WbAlu;   end
                    ClsShift: begin reg_dst = RegDstRd; wb_sel = WbShift; end
                    ClsJal:   begin reg_dst = RegDstRa; wb_sel = WbLink;  end
                    ClsLw:    wb_sel = WbMem;
                    ClsLui:   wb_sel = WbLui;
                    default:  wb_sel = WbAlu;
                endcase
            end
            StTrap: trap = 1'b1;
            default: state_d = StFetch;
        endcase
    end

    assign state       = state_q;
    assign retired_cnt = cnt_q;

endmodule
